// File: rtl/l1_gluon_seq_pkg.sv
// Shared types and helpers for the Gluon-to-L1 beat sequencer.
package l1_gluon_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESP     = 2'd3
    } seq_state_e;

    // Masks are zero-extended to this width before searching.
    localparam int MAX_BEATS  = 32;
    localparam int BEAT_IDX_W = 5;

    function automatic logic [BEAT_IDX_W-1:0] lowest_set_idx(input logic [MAX_BEATS-1:0] mask);
        logic [BEAT_IDX_W-1:0] idx;
        idx = {BEAT_IDX_W{1'b0}};
        for (int i = MAX_BEATS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = BEAT_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/l1_gluon_beat_picker.sv
// Combinational selection of the lowest pending beat in a mask.
module l1_gluon_beat_picker
    import l1_gluon_seq_pkg::*;
#(
    parameter int NUM_BEATS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_BEATS-1:0] pend_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    logic [MAX_BEATS-1:0] pend_wide_s;

    // Widen the mask and pick its lowest set beat.
    always_comb begin
        pend_wide_s                 = {MAX_BEATS{1'b0}};
        pend_wide_s[NUM_BEATS-1:0]  = pend_i;
        idx_o                       = IDX_W'(lowest_set_idx(pend_wide_s));
        any_o                       = |pend_i;
    end

endmodule

// File: rtl/l1_gluon_beat_sequencer.sv
// Splits one multi-beat Gluon request into ordered single-beat L1 requests and
// gathers read data into one Gluon response. Write acks: L1_GLUON_SEQ_WR_ACK_EN.
module l1_gluon_beat_sequencer
    import l1_gluon_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_BEATS  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_BEATS*ADDR_WIDTH-1:0] gl_req_addr,
    input  logic [DATA_WIDTH-1:0]           gl_req_data,
    input  logic                            gl_req_rw,
    input  logic [NUM_BEATS-1:0]            gl_req_valid,
    output logic                            gl_req_ready,
    output logic [ADDR_WIDTH-1:0]           l1_req_addr,
    output logic [DATA_WIDTH-1:0]           l1_req_data,
    output logic                            l1_req_rw,
    output logic                            l1_req_valid,
    input  logic                            l1_req_ready,
    input  logic [DATA_WIDTH-1:0]           l1_rsp_data,
    input  logic                            l1_rsp_valid,
    output logic [NUM_BEATS*DATA_WIDTH-1:0] gl_rsp_data,
    output logic [NUM_BEATS-1:0]            gl_rsp_valid
);

    localparam int IDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    seq_state_e                    state_q;
    logic [ADDR_WIDTH-1:0]         addr_q [NUM_BEATS];
    logic [DATA_WIDTH-1:0]         wdata_q;
    logic                          rw_q;
    logic [NUM_BEATS-1:0]          mask_q;
    logic [NUM_BEATS-1:0]          issued_q;
    logic [NUM_BEATS-1:0]          responded_q;
    logic [DATA_WIDTH-1:0]         slot_q [NUM_BEATS];
    logic [IDX_W-1:0]              cur_idx_q;

    logic                          gl_req_ready_q;
    logic                          l1_req_valid_q;
    logic [ADDR_WIDTH-1:0]         l1_req_addr_q;
    logic [DATA_WIDTH-1:0]         l1_req_data_q;
    logic                          l1_req_rw_q;
    logic [NUM_BEATS-1:0]          gl_rsp_valid_q;
    logic [NUM_BEATS*DATA_WIDTH-1:0] gl_rsp_data_q;

    logic [ADDR_WIDTH-1:0]         req_addr_s [NUM_BEATS];
    logic [DATA_WIDTH-1:0]         slot_nxt_s [NUM_BEATS];
    logic [NUM_BEATS*DATA_WIDTH-1:0] slot_flat_s;
    logic [NUM_BEATS-1:0]          iss_oh_s;
    logic [NUM_BEATS-1:0]          rsp_oh_s;
    logic [NUM_BEATS-1:0]          issued_nxt_s;
    logic [NUM_BEATS-1:0]          responded_nxt_s;
    logic [NUM_BEATS-1:0]          iss_pend_s;
    logic [NUM_BEATS-1:0]          rsp_pend_s;
    logic [IDX_W-1:0]              acc_idx_s;
    logic [IDX_W-1:0]              iss_idx_s;
    logic [IDX_W-1:0]              rsp_idx_s;
    logic                          acc_any_s;
    logic                          iss_any_s;
    logic                          rsp_any_s;
    logic                          accept_s;
    logic                          iss_fire_s;
    logic                          rsp_take_s;
    logic                          all_rsp_s;

    assign gl_req_ready = gl_req_ready_q;
    assign l1_req_valid = l1_req_valid_q;
    assign l1_req_addr  = l1_req_addr_q;
    assign l1_req_data  = l1_req_data_q;
    assign l1_req_rw    = l1_req_rw_q;
    assign gl_rsp_valid = gl_rsp_valid_q;
    assign gl_rsp_data  = gl_rsp_data_q;

    l1_gluon_beat_picker #(.NUM_BEATS(NUM_BEATS), .IDX_W(IDX_W)) u_acc_pick (
        .pend_i (gl_req_valid),
        .idx_o  (acc_idx_s),
        .any_o  (acc_any_s)
    );

    l1_gluon_beat_picker #(.NUM_BEATS(NUM_BEATS), .IDX_W(IDX_W)) u_iss_pick (
        .pend_i (iss_pend_s),
        .idx_o  (iss_idx_s),
        .any_o  (iss_any_s)
    );

    l1_gluon_beat_picker #(.NUM_BEATS(NUM_BEATS), .IDX_W(IDX_W)) u_rsp_pick (
        .pend_i (rsp_pend_s),
        .idx_o  (rsp_idx_s),
        .any_o  (rsp_any_s)
    );

    // Handshake qualifiers and the beat bookkeeping as it stands after this edge.
    always_comb begin
        accept_s   = gl_req_ready_q & acc_any_s & (state_q == ST_IDLE);
        iss_fire_s = l1_req_valid_q & l1_req_ready;
        rsp_pend_s = mask_q & ~responded_q;
        rsp_take_s = l1_rsp_valid & ~rw_q & rsp_any_s &
                     ((state_q == ST_ISSUE) | (state_q == ST_WAIT_RSP));
        for (int i = 0; i < NUM_BEATS; i++) begin
            req_addr_s[i] = gl_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            iss_oh_s[i]   = iss_fire_s & (cur_idx_q == IDX_W'(i));
            rsp_oh_s[i]   = rsp_take_s & (rsp_idx_s == IDX_W'(i));
            slot_nxt_s[i] = rsp_oh_s[i] ? l1_rsp_data : slot_q[i];
            slot_flat_s[i*DATA_WIDTH +: DATA_WIDTH] = slot_nxt_s[i];
        end
        issued_nxt_s    = issued_q | iss_oh_s;
        responded_nxt_s = responded_q | rsp_oh_s;
        iss_pend_s      = mask_q & ~issued_nxt_s;
        all_rsp_s       = ~|(mask_q & ~responded_nxt_s);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wdata_q        <= {DATA_WIDTH{1'b0}};
            rw_q           <= 1'b0;
            mask_q         <= {NUM_BEATS{1'b0}};
            issued_q       <= {NUM_BEATS{1'b0}};
            responded_q    <= {NUM_BEATS{1'b0}};
            cur_idx_q      <= {IDX_W{1'b0}};
            for (int i = 0; i < NUM_BEATS; i++) begin
                addr_q[i] <= {ADDR_WIDTH{1'b0}};
                slot_q[i] <= {DATA_WIDTH{1'b0}};
            end
            gl_req_ready_q <= 1'b1;
            l1_req_valid_q <= 1'b0;
            l1_req_addr_q  <= {ADDR_WIDTH{1'b0}};
            l1_req_data_q  <= {DATA_WIDTH{1'b0}};
            l1_req_rw_q    <= 1'b0;
            gl_rsp_valid_q <= {NUM_BEATS{1'b0}};
            gl_rsp_data_q  <= {(NUM_BEATS*DATA_WIDTH){1'b0}};
        end else begin
            gl_rsp_valid_q <= {NUM_BEATS{1'b0}};
            gl_rsp_data_q  <= {(NUM_BEATS*DATA_WIDTH){1'b0}};
            if (rsp_take_s) begin
                responded_q <= responded_nxt_s;
                for (int i = 0; i < NUM_BEATS; i++) begin
                    slot_q[i] <= slot_nxt_s[i];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < NUM_BEATS; i++) begin
                            addr_q[i] <= req_addr_s[i];
                            slot_q[i] <= {DATA_WIDTH{1'b0}};
                        end
                        wdata_q        <= gl_req_data;
                        rw_q           <= gl_req_rw;
                        mask_q         <= gl_req_valid;
                        issued_q       <= {NUM_BEATS{1'b0}};
                        responded_q    <= {NUM_BEATS{1'b0}};
                        cur_idx_q      <= acc_idx_s;
                        gl_req_ready_q <= 1'b0;
                        l1_req_valid_q <= 1'b1;
                        l1_req_addr_q  <= req_addr_s[acc_idx_s];
                        l1_req_data_q  <= gl_req_data;
                        l1_req_rw_q    <= gl_req_rw;
                        state_q        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (iss_fire_s) begin
                        issued_q <= issued_nxt_s;
                        if (iss_any_s) begin
                            cur_idx_q     <= iss_idx_s;
                            l1_req_addr_q <= addr_q[iss_idx_s];
                        end else begin
                            l1_req_valid_q <= 1'b0;
                            l1_req_addr_q  <= {ADDR_WIDTH{1'b0}};
                            l1_req_data_q  <= {DATA_WIDTH{1'b0}};
                            l1_req_rw_q    <= 1'b0;
                            if (rw_q) begin
`ifdef L1_GLUON_SEQ_WR_ACK_EN
                                gl_rsp_valid_q <= mask_q;
                                state_q        <= ST_RESP;
`else
                                gl_req_ready_q <= 1'b1;
                                state_q        <= ST_IDLE;
`endif
                            end else begin
                                state_q <= ST_WAIT_RSP;
                            end
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (all_rsp_s) begin
                        gl_rsp_valid_q <= mask_q;
                        gl_rsp_data_q  <= slot_flat_s;
                        state_q        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    gl_req_ready_q <= 1'b1;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    gl_req_ready_q <= 1'b1;
                    l1_req_valid_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_gluon_beat_sequencer.sv
// Directed self-checking bench for l1_gluon_beat_sequencer.
module tb_l1_gluon_beat_sequencer;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int NB = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NB*AW-1:0] gl_req_addr;
    logic [DW-1:0]   gl_req_data;
    logic            gl_req_rw;
    logic [NB-1:0]   gl_req_valid;
    logic            gl_req_ready;
    logic [AW-1:0]   l1_req_addr;
    logic [DW-1:0]   l1_req_data;
    logic            l1_req_rw;
    logic            l1_req_valid;
    logic            l1_req_ready;
    logic [DW-1:0]   l1_rsp_data;
    logic            l1_rsp_valid;
    logic [NB*DW-1:0] gl_rsp_data;
    logic [NB-1:0]   gl_rsp_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    l1_gluon_beat_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BEATS(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gl_req_addr  (gl_req_addr),
        .gl_req_data  (gl_req_data),
        .gl_req_rw    (gl_req_rw),
        .gl_req_valid (gl_req_valid),
        .gl_req_ready (gl_req_ready),
        .l1_req_addr  (l1_req_addr),
        .l1_req_data  (l1_req_data),
        .l1_req_rw    (l1_req_rw),
        .l1_req_valid (l1_req_valid),
        .l1_req_ready (l1_req_ready),
        .l1_rsp_data  (l1_rsp_data),
        .l1_rsp_valid (l1_rsp_valid),
        .gl_rsp_data  (gl_rsp_data),
        .gl_rsp_valid (gl_rsp_valid)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        gl_req_addr  = '0;
        gl_req_data  = '0;
        gl_req_rw    = 1'b0;
        gl_req_valid = 2'b00;
        l1_req_ready = 1'b1;
        l1_rsp_data  = '0;
        l1_rsp_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gl_req_ready", gl_req_ready, 1);
        chk("rst_l1_req_valid", l1_req_valid, 0);
        chk("rst_l1_req_addr", l1_req_addr, 0);
        chk("rst_l1_req_data", l1_req_data, 0);
        chk("rst_l1_req_rw", l1_req_rw, 0);
        chk("rst_gl_rsp_valid", gl_rsp_valid, 0);
        chk("rst_gl_rsp_slot0", gl_rsp_data[DW-1:0], 0);
        chk("rst_gl_rsp_slot1", gl_rsp_data[2*DW-1:DW], 0);
        rst_n = 1'b1;

        // Read, full mask, latency 2
        @(negedge clk);
        gl_req_valid = 2'b11;
        gl_req_addr  = {64'h140, 64'h100};
        gl_req_rw    = 1'b0;
        @(negedge clk);
        chk("t1_b0_valid", l1_req_valid, 1);
        chk("t1_b0_addr", l1_req_addr, 64'h100);
        chk("t1_b0_rw", l1_req_rw, 0);
        chk("t1_busy_ready", gl_req_ready, 0);
        gl_req_valid = 2'b00;
        @(negedge clk);
        chk("t1_b1_valid", l1_req_valid, 1);
        chk("t1_b1_addr", l1_req_addr, 64'h140);
        @(negedge clk);
        chk("t1_issue_done", l1_req_valid, 0);
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'hAA;
        @(negedge clk);
        chk("t1_no_early_pulse", gl_rsp_valid, 2'b00);
        l1_rsp_data  = 512'hBB;
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t1_rsp_valid", gl_rsp_valid, 2'b11);
        chk("t1_slot0", gl_rsp_data[DW-1:0], 512'hAA);
        chk("t1_slot1", gl_rsp_data[2*DW-1:DW], 512'hBB);
        chk("t1_ready_in_resp", gl_req_ready, 0);
        @(negedge clk);
        chk("t1_pulse_end", gl_rsp_valid, 2'b00);
        chk("t1_ready_back", gl_req_ready, 1);

        // Read, sparse mask 2'b10
        @(negedge clk);
        gl_req_valid = 2'b10;
        gl_req_addr  = {64'h200, 64'h999};
        @(negedge clk);
        chk("t2_valid", l1_req_valid, 1);
        chk("t2_addr", l1_req_addr, 64'h200);
        gl_req_valid = 2'b00;
        @(negedge clk);
        chk("t2_single_req", l1_req_valid, 0);
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'hCC;
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t2_rsp_valid", gl_rsp_valid, 2'b10);
        chk("t2_slot0_zero", gl_rsp_data[DW-1:0], 0);
        chk("t2_slot1", gl_rsp_data[2*DW-1:DW], 512'hCC);
        @(negedge clk);
        chk("t2_ready_back", gl_req_ready, 1);

        // Write with three stall cycles
        @(negedge clk);
        gl_req_valid = 2'b11;
        gl_req_addr  = {64'h340, 64'h300};
        gl_req_data  = 512'h5A;
        gl_req_rw    = 1'b1;
        l1_req_ready = 1'b0;
        @(negedge clk);
        gl_req_valid = 2'b00;
        chk("t3_stall1_valid", l1_req_valid, 1);
        chk("t3_stall1_addr", l1_req_addr, 64'h300);
        chk("t3_stall1_data", l1_req_data, 512'h5A);
        chk("t3_stall1_rw", l1_req_rw, 1);
        @(negedge clk);
        chk("t3_stall2_addr", l1_req_addr, 64'h300);
        chk("t3_stall2_data", l1_req_data, 512'h5A);
        @(negedge clk);
        chk("t3_stall3_addr", l1_req_addr, 64'h300);
        chk("t3_stall3_valid", l1_req_valid, 1);
        l1_req_ready = 1'b1;
        @(negedge clk);
        chk("t3_b1_valid", l1_req_valid, 1);
        chk("t3_b1_addr", l1_req_addr, 64'h340);
        chk("t3_b1_data", l1_req_data, 512'h5A);
        @(negedge clk);
        chk("t3_issue_done", l1_req_valid, 0);
`ifdef L1_GLUON_SEQ_WR_ACK_EN
        chk("t3_ack_valid", gl_rsp_valid, 2'b11);
        chk("t3_ack_slot0", gl_rsp_data[DW-1:0], 0);
        chk("t3_ack_slot1", gl_rsp_data[2*DW-1:DW], 0);
        chk("t3_ready_in_resp", gl_req_ready, 0);
`else
        chk("t3_no_rsp", gl_rsp_valid, 2'b00);
        chk("t3_ready_back", gl_req_ready, 1);
`endif
        @(negedge clk);
        chk("t3_rsp_idle", gl_rsp_valid, 2'b00);
        chk("t3_ready_final", gl_req_ready, 1);
        gl_req_rw   = 1'b0;
        gl_req_data = '0;

        // Stray responses in IDLE, then a clean read
        @(negedge clk);
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'hDEAD;
        @(negedge clk);
        chk("t4_stray_ready", gl_req_ready, 1);
        chk("t4_stray_rsp", gl_rsp_valid, 2'b00);
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t4_stray_ready2", gl_req_ready, 1);
        chk("t4_stray_l1", l1_req_valid, 0);
        gl_req_valid = 2'b01;
        gl_req_addr  = {64'h0, 64'h400};
        @(negedge clk);
        chk("t4_addr", l1_req_addr, 64'h400);
        gl_req_valid = 2'b00;
        @(negedge clk);
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'hEE;
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t4_rsp_valid", gl_rsp_valid, 2'b01);
        chk("t4_slot0", gl_rsp_data[DW-1:0], 512'hEE);
        chk("t4_slot1_zero", gl_rsp_data[2*DW-1:DW], 0);

        // Read, latency 1: response and issue handshake on the same edge
        @(negedge clk);
        gl_req_valid = 2'b11;
        gl_req_addr  = {64'h1C0, 64'h180};
        @(negedge clk);
        gl_req_valid = 2'b00;
        chk("t5_b0_addr", l1_req_addr, 64'h180);
        @(negedge clk);
        chk("t5_b1_addr", l1_req_addr, 64'h1C0);
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'h11;
        @(negedge clk);
        chk("t5_issue_done", l1_req_valid, 0);
        l1_rsp_data  = 512'h22;
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t5_rsp_valid", gl_rsp_valid, 2'b11);
        chk("t5_slot0", gl_rsp_data[DW-1:0], 512'h11);
        chk("t5_slot1", gl_rsp_data[2*DW-1:DW], 512'h22);

        // Reset mid-read, late response dropped, then a fresh read
        @(negedge clk);
        gl_req_valid = 2'b11;
        gl_req_addr  = {64'h6C0, 64'h680};
        @(negedge clk);
        gl_req_valid = 2'b00;
        chk("t6_b0_addr", l1_req_addr, 64'h680);
        @(negedge clk);
        chk("t6_b1_addr", l1_req_addr, 64'h6C0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_l1_valid", l1_req_valid, 0);
        chk("t6_rst_l1_addr", l1_req_addr, 0);
        chk("t6_rst_ready", gl_req_ready, 1);
        chk("t6_rst_rsp", gl_rsp_valid, 2'b00);
        @(negedge clk);
        rst_n        = 1'b1;
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'hBAD;
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t6_late_ready", gl_req_ready, 1);
        chk("t6_late_l1", l1_req_valid, 0);
        chk("t6_late_rsp", gl_rsp_valid, 2'b00);
        gl_req_valid = 2'b01;
        gl_req_addr  = {64'h0, 64'h700};
        @(negedge clk);
        gl_req_valid = 2'b00;
        chk("t6_new_valid", l1_req_valid, 1);
        chk("t6_new_addr", l1_req_addr, 64'h700);
        @(negedge clk);
        l1_rsp_valid = 1'b1;
        l1_rsp_data  = 512'h77;
        @(negedge clk);
        l1_rsp_valid = 1'b0;
        chk("t6_rsp_valid", gl_rsp_valid, 2'b01);
        chk("t6_slot0", gl_rsp_data[DW-1:0], 512'h77);
        chk("t6_slot1_zero", gl_rsp_data[2*DW-1:DW], 0);
        @(negedge clk);
        chk("t6_ready_back", gl_req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
